crc_check: RTL
==============

// Module: crc_check
// PURPOSE
//  Receive-side counterpart of the DMA CRC generator. Consumes a block of WORDS
//  32-bit data words followed by one expected-CRC word over a valid/ready stream.
//  Computes CRC-32 (poly 0x04C11DB7, MSB-first, no reflection, no final XOR) one
//  word per cycle and flags match/mismatch. Sits on the DMA read-back path and is
//  armed by the DMA controller when a transfer completes.
// PARAMETERS
//  WORDS     8             data words per block (1..255), excludes CRC word
//  CRC_INIT  32'hFFFFFFFF  CRC register seed loaded on start
//  POLY      32'h04C11DB7  generator polynomial, implicit x^32 term
// PORTS
//  clk_i         in   1   clock, all state on rising edge
//  reset_n_i     in   1   asynchronous active-low reset
//  start_i       in   1   arm a new check; honoured only in IDLE or DONE
//  abort_i       in   1   return to IDLE from any state, result discarded
//  data_i        in   32  stream word: data words, then expected CRC word
//  data_valid_i  in   1   data_i valid
//  data_ready_o  out  1   block accepts data_i this cycle
//  busy_o        out  1   high in DATA or CRCW
//  done_o        out  1   one-cycle pulse on entry to DONE
//  crc_ok_o      out  1   held: last block matched
//  crc_err_o     out  1   held: last block mismatched
//  crc_calc_o    out  32  running/final computed CRC (data words only)
//  word_cnt_o    out  8   data words accepted in current block
// BEHAVIOUR
//  Reset: state=IDLE; data_ready_o=0, busy_o=0, done_o=0, crc_ok_o=0,
//   crc_err_o=0, crc_calc_o=0, word_cnt_o=0.
//  Transfer: word accepted iff data_valid_i && data_ready_o on a rising edge.
//   data_ready_o=1 only in DATA and CRCW (registered-state decode, no comb
//   path from data_valid_i). data_i must be stable while valid && !ready.
//  FSM:
//   IDLE -> DATA on start_i: crc_calc_o<=CRC_INIT, word_cnt_o<=0,
//          crc_ok_o<=0, crc_err_o<=0.
//   DATA: each accepted word: crc_calc_o<=f(crc_calc_o,data_i), word_cnt_o+1.
//          On the WORDS-th accepted word -> CRCW.
//   CRCW: accepted word compared to crc_calc_o; crc_ok_o<=(equal),
//          crc_err_o<=!(equal); -> DONE; done_o=1 next cycle only.
//   DONE: results held; start_i -> DATA (as from IDLE); else stay.
//  Word update f: 32 serial steps, bit 31 of data first; per bit b:
//   fb=crc[31]^b; crc=(crc<<1)^(fb?POLY:0). Single-cycle combinational fold.
//  Latency: last CRC word accepted in cycle N -> crc_ok_o/crc_err_o/done_o
//   valid in cycle N+1. Throughput 1 word/cycle; block of WORDS takes WORDS+1
//   accepted beats min.
//  Boundaries:
//   - abort_i and start_i same cycle: abort wins, IDLE, outputs as reset except
//     crc_calc_o/word_cnt_o hold.
//   - start_i in DATA/CRCW ignored; data_valid_i in IDLE/DONE ignored (ready=0).
//   - data_valid_i gaps in DATA/CRCW: state and CRC hold.
//   - word_cnt_o never exceeds WORDS; no wrap.
//   - reset asserted mid-block: immediate return to reset values.
// TESTING
//  1 CRC_INIT=0, WORDS=1, data 0x00000001 then CRC 0x04C11DB7 -> crc_calc_o=
//    0x04C11DB7, crc_ok_o=1, crc_err_o=0, done_o one pulse cycle after CRC beat.
//  2 CRC_INIT=0, WORDS=8, eight 0x00000000 words, CRC 0x00000000 -> crc_ok_o=1;
//    repeat with CRC 0x00000001 -> crc_err_o=1, crc_ok_o=0.
//  3 Default params, random 8 words + model CRC, random valid gaps -> crc_ok_o=1,
//    crc_calc_o equals model; flip bit 0 of word 3 -> crc_err_o=1.
//  4 abort_i asserted after 4 data words -> IDLE next cycle, busy_o=0,
//    data_ready_o=0, no done_o; next start_i gives fresh correct result.
//  5 start_i pulsed in DATA and abort_i+start_i together in IDLE -> both ignored,
//    word_cnt_o/crc_calc_o undisturbed, state per rules above.
//  6 reset_n_i low mid-block (word 5), asynchronously -> all outputs reset value
//    same cycle; data_valid_i held high yields no acceptance until start_i.

Source files
------------

// File: rtl/crc_check.sv
// Receive-side CRC-32 checker: folds WORDS data words one per cycle, then compares
// the running CRC against the trailing expected-CRC word and holds the verdict.
module crc_check #(
   parameter int unsigned WORDS    = 8,
   parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF,
   parameter logic [31:0] POLY     = 32'h04C11DB7
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [31:0] data_i,
   input  logic        data_valid_i,
   output logic        data_ready_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        crc_ok_o,
   output logic        crc_err_o,
   output logic [31:0] crc_calc_o,
   output logic [7:0]  word_cnt_o
);

   typedef enum logic [1:0] {StIdle, StData, StCrcw, StDone} state_t;

   localparam logic [7:0] LastIdx = 8'(WORDS - 1);

   state_t      r_state;
   logic        r_done;
   logic        r_ok;
   logic        r_err;
   logic [31:0] r_crc;
   logic [7:0]  r_cnt;

   logic [31:0] w_crc_next;
   logic        w_accept;

   // MSB-first serial CRC unrolled into one combinational fold per word
   function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [31:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
         else              c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

   always_comb begin
      w_crc_next = crc_fold(r_crc, data_i);
   end

   assign data_ready_o = (r_state == StData) || (r_state == StCrcw);
   assign busy_o       = data_ready_o;
   assign w_accept     = data_valid_i && data_ready_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= StIdle;
         r_done  <= 1'b0;
         r_ok    <= 1'b0;
         r_err   <= 1'b0;
         r_crc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         if (abort_i) begin
            // crc/count are left as-is for debug visibility after an abort
            r_state <= StIdle;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle, StDone: begin
                  if (start_i) begin
                     r_state <= StData;
                     r_crc   <= CRC_INIT;
                     r_cnt   <= '0;
                     r_ok    <= 1'b0;
                     r_err   <= 1'b0;
                  end
               end
               StData: begin
                  if (w_accept) begin
                     r_crc <= w_crc_next;
                     r_cnt <= r_cnt + 8'd1;
                     if (r_cnt == LastIdx) r_state <= StCrcw;
                  end
               end
               StCrcw: begin
                  if (w_accept) begin
                     r_ok    <= (data_i == r_crc);
                     r_err   <= (data_i != r_crc);
                     r_done  <= 1'b1;
                     r_state <= StDone;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign done_o     = r_done;
   assign crc_ok_o   = r_ok;
   assign crc_err_o  = r_err;
   assign crc_calc_o = r_crc;
   assign word_cnt_o = r_cnt;

endmodule
